valu_dotp_ctrl: RTL and testbench
=================================

// Module: valu_dotp_ctrl
// PURPOSE
//  Sequencer for the 4x8-bit signed vector MAC ALU (valu). Accepts a dot-product command
//  (length N, initial accumulator), streams N operand-word pairs through the valu, and
//  accumulates the per-word results. Returns one 32-bit result through a valid/ready handshake.
//  Sits between the issue/operand stage and the combinational valu datapath.
// PARAMETERS
//  LEN_W   8  width of cmd_len_i; max N = 2**LEN_W-1
//  SAT_EN  0  1: saturate the accumulator to signed 32-bit; 0: two's-complement wrap
// PORTS
//  clk_i            in   1      clock
//  rst_ni           in   1      asynchronous reset, active low
//  cmd_valid_i      in   1      command valid
//  cmd_ready_o      out  1      command ready (1 only in IDLE)
//  cmd_len_i        in   LEN_W  number of operand pairs N
//  cmd_init_i       in   32     initial accumulator value (signed)
//  op_valid_i       in   1      operand pair valid
//  op_ready_o       out  1      operand pair ready
//  op_a_i           in   32     packed 4x int8 operand A
//  op_b_i           in   32     packed 4x int8 operand B
//  valu_operand_a_o out  32     to valu operand A
//  valu_operand_b_o out  32     to valu operand B
//  valu_ready_i     in   1      valu ready
//  valu_result_i    in   32     valu result (signed sum of 4 int8 products, combinational)
//  res_valid_o      out  1      result valid
//  res_ready_i      in   1      result ready
//  res_data_o       out  32     accumulated result
//  res_ovf_o        out  1      sticky signed overflow seen during this command
//  busy_o           out  1      state != IDLE
// BEHAVIOUR
//  - Reset: state=IDLE, acc=0, remaining=0, prod_vld=0, ovf=0; all outputs 0 except cmd_ready_o=1.
//  - FSM states: IDLE, RUN, DRAIN, DONE.
//  - IDLE: on cmd_valid_i&cmd_ready_o, latch acc<=cmd_init_i, remaining<=cmd_len_i, ovf<=0.
//    Go to DONE if N==0, otherwise go to RUN.
//  - RUN: op_ready_o=valu_ready_i. valu_operand_*_o=op_*_i in RUN, and 0 in all other states.
//    An op handshake (op_valid_i&op_ready_o) captures prod<=valu_result_i and sets prod_vld<=1.
//    It also decrements remaining. The handshake that brings remaining to 0 moves the FSM to DRAIN.
//  - Accumulate stage: in any cycle with prod_vld=1, acc<=acc+prod. prod_vld clears unless
//    a new handshake occurs in the same cycle. This supports 1 pair/cycle back-to-back.
//  - Add width: 33-bit signed sum. Overflow when the sum is outside [-2^31, 2^31-1]; this sets ovf (sticky).
//    SAT_EN=1 clamps to 0x7FFFFFFF or 0x80000000. SAT_EN=0 keeps the low 32 bits.
//  - DRAIN: wait one cycle for the last prod to accumulate, then go to DONE.
//  - DONE: res_valid_o=1, res_data_o=acc, res_ovf_o=ovf. These hold stable until res_ready_i.
//    The handshake returns the FSM to IDLE. A new command is accepted no earlier than the next cycle.
//  - Latency: last op handshake at cycle t gives res_valid_o at t+2. N==0 gives res_valid_o
//    the cycle after the cmd handshake, with res_data_o=cmd_init_i.
//  - Stall: valu_ready_i=0 or op_valid_i=0 in RUN causes no state change. Pending prod still accumulates.
//  - cmd_valid_i outside IDLE is ignored (not accepted). op_valid_i outside RUN is ignored.
//  - Reset asserted mid-operation aborts immediately to reset values. No result is produced.
// TESTING
//  - N=3, init=0, each pair A=0x01010101, B=0x02020202 -> res_data_o=24, ovf=0,
//    res_valid_o 2 cycles after 3rd handshake.
//  - N=1, init=10, A=0xFFFFFFFF, B=0x01010101 -> res_data_o=6 (10-4).
//  - N=0, init=0x12345678 -> res_valid_o next cycle, res_data_o=0x12345678, no op_ready_o pulse.
//  - SAT_EN=0, N=1, init=0x7FFFFFFF, A=B=0x01010101 -> res_data_o=0x80000003, res_ovf_o=1.
//    SAT_EN=1 same stimulus -> 0x7FFFFFFF, res_ovf_o=1.
//  - N=4 with valu_ready_i low 3 cycles mid-stream and res_ready_i low 2 cycles -> no
//    duplicate/lost pairs, result equals reference sum, res_data_o stable while waiting.
//  - Assert rst_ni after 2 of N=4 handshakes -> all outputs at reset values.
//    Next command N=1, init=0, A=B=0x01010101 -> 4.

Source files
------------

// File: rtl/valu_dotp_ctrl.sv
// Dot-product sequencer for the 4x int8 vector MAC ALU: streams N operand pairs through the
// combinational valu, accumulates the per-word results and returns one 32-bit sum.
module valu_dotp_ctrl #(
    parameter int LEN_W  = 8,
    parameter bit SAT_EN = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [LEN_W-1:0] cmd_len_i,
    input  logic [31:0]      cmd_init_i,
    input  logic             op_valid_i,
    output logic             op_ready_o,
    input  logic [31:0]      op_a_i,
    input  logic [31:0]      op_b_i,
    output logic [31:0]      valu_operand_a_o,
    output logic [31:0]      valu_operand_b_o,
    input  logic             valu_ready_i,
    input  logic [31:0]      valu_result_i,
    output logic             res_valid_o,
    input  logic             res_ready_i,
    output logic [31:0]      res_data_o,
    output logic             res_ovf_o,
    output logic             busy_o
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t           state, state_nxt;
    logic [31:0]      acc;
    logic [31:0]      prod;
    logic [LEN_W-1:0] remaining;
    logic             prod_vld;
    logic             ovf;

    logic             cmd_fire;
    logic             op_fire;
    logic             last_op;
    logic [32:0]      sum;
    logic             sum_ovf;
    logic [31:0]      acc_upd;

    // Handshakes are decoded from state directly so they do not loop through the ready outputs.
    assign cmd_fire = (state == IDLE) && cmd_valid_i;
    assign op_fire  = (state == RUN) && valu_ready_i && op_valid_i;
    assign last_op  = op_fire && (remaining == LEN_W'(1));

    // 33-bit signed add: overflow whenever the two top bits disagree.
    assign sum     = {acc[31], acc} + {prod[31], prod};
    assign sum_ovf = sum[32] ^ sum[31];

    always_comb begin
        acc_upd = sum[31:0];
        if (SAT_EN && sum_ovf) begin
            acc_upd = sum[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end
    end

    // NOTE: non-blocking assignments in clocked blocks so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every output and next-state term gets a default first so no latch is inferred.
    always_comb begin
        state_nxt        = state;
        cmd_ready_o      = 1'b0;
        op_ready_o       = 1'b0;
        valu_operand_a_o = 32'h0;
        valu_operand_b_o = 32'h0;
        res_valid_o      = 1'b0;
        res_data_o       = 32'h0;
        res_ovf_o        = 1'b0;
        busy_o           = 1'b1;
        unique case (state)
            IDLE: begin
                cmd_ready_o = 1'b1;
                busy_o      = 1'b0;
                if (cmd_valid_i) begin
                    state_nxt = (cmd_len_i == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                op_ready_o       = valu_ready_i;
                valu_operand_a_o = op_a_i;
                valu_operand_b_o = op_b_i;
                if (last_op) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                state_nxt = DONE;
            end
            DONE: begin
                res_valid_o = 1'b1;
                res_data_o  = acc;
                res_ovf_o   = ovf;
                if (res_ready_i) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc       <= 32'h0;
            remaining <= '0;
            prod_vld  <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            if (cmd_fire) begin
                acc       <= cmd_init_i;
                remaining <= cmd_len_i;
                ovf       <= 1'b0;
            end else if (prod_vld) begin
                acc <= acc_upd;
                if (sum_ovf) begin
                    ovf <= 1'b1;
                end
            end
            if (op_fire) begin
                remaining <= remaining - LEN_W'(1);
                prod_vld  <= 1'b1;
            end else begin
                prod_vld <= 1'b0;
            end
        end
    end

    // NOTE: prod is a pure data register; it is only consumed while prod_vld is set, so it needs no reset.
    always_ff @(posedge clk_i) begin
        if (op_fire) begin
            prod <= valu_result_i;
        end
    end

endmodule

// File: tb/tb_valu_dotp_ctrl.sv
// Scoreboard bench for valu_dotp_ctrl: a wrapping and a saturating instance run in lockstep,
// a behavioural valu feeds each, and a monitor checks every presented result against a queue.
module tb_valu_dotp_ctrl;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic [7:0]  cmd_len;
    logic [31:0] cmd_init;
    logic        op_valid;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        valu_ready;
    logic        res_ready;

    logic        cmd_ready_w, op_ready_w, res_valid_w, res_ovf_w, busy_w;
    logic [31:0] opnd_a_w, opnd_b_w, valu_result_w, res_data_w;
    logic        cmd_ready_s, op_ready_s, res_valid_s, res_ovf_s, busy_s;
    logic [31:0] opnd_a_s, opnd_b_s, valu_result_s, res_data_s;

    logic [32:0] q_w[$];
    logic [32:0] q_s[$];
    int          n_cmp = 0;
    int          n_err = 0;

    function automatic logic [31:0] dot4(input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] s;
        logic signed [15:0] p;
        s = 32'sd0;
        for (int i = 0; i < 4; i++) begin
            p = $signed(a[8*i +: 8]) * $signed(b[8*i +: 8]);
            s = s + 32'(p);
        end
        return s;
    endfunction

    assign valu_result_w = dot4(opnd_a_w, opnd_b_w);
    assign valu_result_s = dot4(opnd_a_s, opnd_b_s);

    valu_dotp_ctrl #(.LEN_W(8), .SAT_EN(1'b0)) dut_w (
        .clk_i(clk), .rst_ni(rst_n),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready_w), .cmd_len_i(cmd_len), .cmd_init_i(cmd_init),
        .op_valid_i(op_valid), .op_ready_o(op_ready_w), .op_a_i(op_a), .op_b_i(op_b),
        .valu_operand_a_o(opnd_a_w), .valu_operand_b_o(opnd_b_w),
        .valu_ready_i(valu_ready), .valu_result_i(valu_result_w),
        .res_valid_o(res_valid_w), .res_ready_i(res_ready), .res_data_o(res_data_w),
        .res_ovf_o(res_ovf_w), .busy_o(busy_w)
    );

    valu_dotp_ctrl #(.LEN_W(8), .SAT_EN(1'b1)) dut_s (
        .clk_i(clk), .rst_ni(rst_n),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready_s), .cmd_len_i(cmd_len), .cmd_init_i(cmd_init),
        .op_valid_i(op_valid), .op_ready_o(op_ready_s), .op_a_i(op_a), .op_b_i(op_b),
        .valu_operand_a_o(opnd_a_s), .valu_operand_b_o(opnd_b_s),
        .valu_ready_i(valu_ready), .valu_result_i(valu_result_s),
        .res_valid_o(res_valid_s), .res_ready_i(res_ready), .res_data_o(res_data_s),
        .res_ovf_o(res_ovf_s), .busy_o(busy_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compare on the falling edge, pop only when the result handshake completes.
    always @(negedge clk) begin
        if (rst_n && res_valid_w) begin
            if (q_w.size() == 0) begin
                check("res_unexpected_w", 1, 0);
            end else begin
                check(res_ready ? "res_data_w" : "res_hold_w", res_data_w, q_w[0][31:0]);
                check("res_ovf_w", res_ovf_w, q_w[0][32]);
                if (res_ready) void'(q_w.pop_front());
            end
        end
        if (rst_n && res_valid_s) begin
            if (q_s.size() == 0) begin
                check("res_unexpected_s", 1, 0);
            end else begin
                check(res_ready ? "res_data_s" : "res_hold_s", res_data_s, q_s[0][31:0]);
                check("res_ovf_s", res_ovf_s, q_s[0][32]);
                if (res_ready) void'(q_s.pop_front());
            end
        end
    end

    task automatic send_cmd(input logic [7:0] len, input logic [31:0] init, input bit push,
                            input logic [31:0] exp_w, input logic [31:0] exp_s, input logic exp_ovf);
        int k = 0;
        @(negedge clk);
        if (push) begin
            q_w.push_back({exp_ovf, exp_w});
            q_s.push_back({exp_ovf, exp_s});
        end
        cmd_valid = 1'b1;
        cmd_len   = len;
        cmd_init  = init;
        while (!cmd_ready_w && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("cmd_accept_in_time", k < 50, 1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic send_op(input logic [31:0] a, input logic [31:0] b);
        int k = 0;
        @(negedge clk);
        op_valid = 1'b1;
        op_a     = a;
        op_b     = b;
        while (!op_ready_w && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("op_accept_in_time", k < 50, 1);
        @(posedge clk);
        #1 op_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int k = 0;
        while ((q_w.size() != 0 || q_s.size() != 0 || busy_w) && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("result_in_time", k < 200, 1);
    endtask

    initial begin
        int k;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_len = 8'd0; cmd_init = 32'h0;
        op_valid = 1'b0; op_a = 32'h0; op_b = 32'h0; valu_ready = 1'b1; res_ready = 1'b1;

        repeat (2) @(negedge clk);
        check("rst_cmd_ready", cmd_ready_w, 1);
        check("rst_op_ready", op_ready_w, 0);
        check("rst_res_valid", res_valid_w, 0);
        check("rst_busy", busy_w, 0);
        rst_n = 1'b1;

        // N=3, 8 per word -> 24, result two cycles after the last handshake
        send_cmd(8'd3, 32'h0, 1'b1, 32'd24, 32'd24, 1'b0);
        for (int i = 0; i < 3; i++) send_op(32'h0101_0101, 32'h0202_0202);
        @(negedge clk);
        check("lat_drain_cycle", res_valid_w, 0);
        @(negedge clk);
        check("lat_done_cycle", res_valid_w, 1);
        wait_idle();

        // N=1, 10 + (-4)
        send_cmd(8'd1, 32'd10, 1'b1, 32'd6, 32'd6, 1'b0);
        send_op(32'hFFFF_FFFF, 32'h0101_0101);
        wait_idle();

        // N=0: result the cycle after the command, no operand pulse
        send_cmd(8'd0, 32'h1234_5678, 1'b1, 32'h1234_5678, 32'h1234_5678, 1'b0);
        @(negedge clk);
        check("n0_res_valid", res_valid_w, 1);
        check("n0_op_ready", op_ready_w, 0);
        wait_idle();

        // Positive overflow: wrap vs saturate, sticky flag on both
        send_cmd(8'd1, 32'h7FFF_FFFF, 1'b1, 32'h8000_0003, 32'h7FFF_FFFF, 1'b1);
        send_op(32'h0101_0101, 32'h0101_0101);
        wait_idle();

        // N=4 with a 3-cycle valu stall mid-stream and a 2-cycle result backpressure
        // 100 + 70 + 2 - 24 + 64516 = 64664
        res_ready = 1'b0;
        send_cmd(8'd4, 32'd100, 1'b1, 32'd64664, 32'd64664, 1'b0);
        fork
            begin
                send_op(32'h0102_0304, 32'h0506_0708);
                send_op(32'h807F_0102, 32'h0101_0101);
                send_op(32'hFEFE_FEFE, 32'h0303_0303);
                send_op(32'h7F7F_7F7F, 32'h7F7F_7F7F);
            end
            begin
                repeat (2) @(posedge clk);
                #1 valu_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 valu_ready = 1'b1;
            end
        join
        k = 0;
        while (!res_valid_w && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("stall_result_seen", k < 50, 1);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 res_ready = 1'b1;
        wait_idle();

        // Reset after 2 of 4 handshakes aborts with no result
        send_cmd(8'd4, 32'd5, 1'b0, 32'h0, 32'h0, 1'b0);
        send_op(32'h0101_0101, 32'h0101_0101);
        send_op(32'h0101_0101, 32'h0101_0101);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_cmd_ready", cmd_ready_w, 1);
        check("abort_op_ready", op_ready_w, 0);
        check("abort_res_valid", res_valid_w, 0);
        check("abort_res_data", res_data_w, 0);
        check("abort_res_ovf", res_ovf_w, 0);
        check("abort_busy", busy_w, 0);
        check("abort_operand_a", opnd_a_w, 0);
        check("abort_operand_b", opnd_b_w, 0);
        @(negedge clk);
        rst_n = 1'b1;
        send_cmd(8'd1, 32'h0, 1'b1, 32'd4, 32'd4, 1'b0);
        send_op(32'h0101_0101, 32'h0101_0101);
        wait_idle();

        repeat (3) @(negedge clk);
        check("queue_w_drained", q_w.size(), 0);
        check("queue_s_drained", q_s.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
